// File: rtl/conv_acc_quant_pkg.sv
// conv_acc_quant_pkg
// Shared definitions for the conv accumulate/quantise output stage:
//   - frac_shift_w : width of the runtime right-shift control
//   - quant_w      : working width of the round/shift/saturate helper
//   - quant_t      : helper result (clamped value plus saturation flag)
//   - round_shift_sat() : round-half-up, arithmetic shift right, clamp
package conv_acc_quant_pkg;

    localparam int unsigned FRAC_SHIFT_W = 6;

    // Accumulator values are sign-extended to this width before quantising,
    // so any acc_width up to 63 is handled by the one helper.
    localparam int unsigned QUANT_W = 64;

    typedef struct packed {
        logic                      sat;
        logic signed [QUANT_W-1:0] data;
    } quant_t;

    // Rounds half up by 2^(shift-1), shifts right arithmetically and clamps
    // into a signed out_w-bit range. One guard bit above the sign-extended
    // input keeps the rounding add from overflowing.
    function automatic quant_t round_shift_sat(
        input logic signed [QUANT_W-1:0]      acc,
        input logic        [FRAC_SHIFT_W-1:0] shift,
        input int unsigned                    out_w
    );
        logic signed [QUANT_W:0] one;
        logic signed [QUANT_W:0] wide;
        logic signed [QUANT_W:0] rnd;
        logic signed [QUANT_W:0] shifted;
        logic signed [QUANT_W:0] max_v;
        logic signed [QUANT_W:0] min_v;
        quant_t                  res;

        one     = {{QUANT_W{1'b0}}, 1'b1};
        wide    = {acc[QUANT_W-1], acc};
        rnd     = (shift != '0) ? (one <<< (shift - 6'd1)) : '0;
        shifted = (wide + rnd) >>> shift;
        max_v   = (one <<< (out_w - 1)) - one;
        min_v   = -max_v - one;

        if (shifted > max_v) begin
            res.sat  = 1'b1;
            res.data = max_v[QUANT_W-1:0];
        end else if (shifted < min_v) begin
            res.sat  = 1'b1;
            res.data = min_v[QUANT_W-1:0];
        end else begin
            res.sat  = 1'b0;
            res.data = shifted[QUANT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_acc_quant_acc_out_fifo.sv
// acc_out_fifo
// Synchronous first-word-fall-through FIFO used as the result buffer of conv
// output stages. The head entry is always visible on rd_data while rd_valid.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (empties FIFO)
//   wr_en, wr_data : push; caller guarantees space unless popping this cycle
//   rd_valid       : FIFO not empty
//   rd_ready       : pop the head when rd_valid && rd_ready
//   rd_data        : head entry
//   count          : current number of stored entries
module acc_out_fifo
    import conv_acc_quant_pkg::*;
#(
    parameter int unsigned width = 17,
    parameter int unsigned depth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [width-1:0]       wr_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [width-1:0]       rd_data,
    output logic [$clog2(depth):0] count
);

    localparam int unsigned AW = $clog2(depth);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop;

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign pop      = rd_valid && rd_ready;

    // A push into a full FIFO together with a pop overwrites the slot being
    // read; the head was already presented combinationally this cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/conv_acc_quant.sv
// conv_acc_quant
// Accumulates signed products over a kernel window (in_first..in_last),
// round/shift/saturates the window sum to out_width bits and buffers the
// result in a FWFT FIFO toward the feature-map writer.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   frac_shift                     : right-shift amount, static while busy
//   in_valid/in_ready              : product beat handshake
//   in_prod, in_first, in_last     : signed product and group delimiters
//   out_valid/out_ready            : result handshake (FIFO head)
//   out_data, out_sat              : quantised result and its saturation flag
// Handshake: a transfer happens on any edge where valid && ready; valid
// holders keep their payload stable until that edge.
module conv_acc_quant
    import conv_acc_quant_pkg::*;
#(
    parameter int unsigned prod_width = 32,
    parameter int unsigned acc_width  = 40,
    parameter int unsigned out_width  = 16,
    parameter int unsigned fifo_depth = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FRAC_SHIFT_W-1:0] frac_shift,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [prod_width-1:0]   in_prod,
    input  logic                    in_first,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [out_width-1:0]    out_data,
    output logic                    out_sat
);

    localparam int unsigned CW = $clog2(fifo_depth);

    logic [acc_width-1:0] acc_q, acc_d;
    logic [acc_width-1:0] done_q, done_d;
    logic                 done_valid_q, done_valid_d;

    logic [acc_width-1:0] prod_sext;
    logic [acc_width-1:0] acc_next;
    logic                 accept;
    quant_t               quant_res;
    logic                 quant_unused;
    logic [out_width:0]   fifo_wdata;
    logic [out_width:0]   fifo_rdata;
    logic [CW:0]          fifo_count;
    logic [CW:0]          occupancy;

    assign prod_sext = acc_width'(signed'(in_prod));
    assign acc_next  = in_first ? prod_sext : (acc_q + prod_sext);

    // The pending done result counts against FIFO space, so whatever sits in
    // the done register always has a slot on the following edge.
    assign occupancy = fifo_count + {{CW{1'b0}}, done_valid_q};
    assign in_ready  = (occupancy < (CW+1)'(fifo_depth));
    assign accept    = in_valid && in_ready;

    always_comb begin
        acc_d        = acc_q;
        done_d       = done_q;
        done_valid_d = 1'b0;
        if (accept) begin
            if (in_last) begin
                done_d       = acc_next;
                done_valid_d = 1'b1;
                acc_d        = '0;
            end else begin
                acc_d = acc_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            done_q       <= '0;
            done_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            done_q       <= done_d;
            done_valid_q <= done_valid_d;
        end
    end

    assign quant_res = round_shift_sat(QUANT_W'(signed'(done_q)), frac_shift,
                                       out_width);
    // After clamping the bits above out_width are only sign copies.
    assign quant_unused = ^quant_res.data[QUANT_W-1:out_width];
    assign fifo_wdata   = {quant_res.sat, quant_res.data[out_width-1:0]};

    acc_out_fifo #(
        .width (out_width + 1),
        .depth (fifo_depth)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (done_valid_q),
        .wr_data  (fifo_wdata),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (fifo_rdata),
        .count    (fifo_count)
    );

    assign out_sat  = fifo_rdata[out_width];
    assign out_data = fifo_rdata[out_width-1:0];

endmodule

// File: tb/tb_conv_acc_quant.sv
// tb_conv_acc_quant
// Directed plus randomised stimulus for conv_acc_quant with a scoreboard of
// expected {sat, data} results compared as the FIFO head is popped.
module tb_conv_acc_quant;

    logic        clk;
    logic        rst;
    logic [5:0]  frac_shift;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_prod;
    logic        in_first;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;

    logic [16:0] exp_q[$];
    int          vectors;
    int          miscompares;

    conv_acc_quant dut (
        .clk        (clk),
        .rst        (rst),
        .frac_shift (frac_shift),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_prod    (in_prod),
        .in_first   (in_first),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference for round-half-up / shift / clamp to 16 bits.
    function automatic logic [16:0] model(input longint s, input int sh);
        longint v;
        v = s;
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (v > 32767)  return {1'b1, 16'h7fff};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    // Drive one beat from posedge+1; it is accepted on the first edge where
    // in_ready is seen high. stalls counts the cycles spent waiting.
    task automatic beat(input logic [31:0] p, input logic f, input logic l,
                        output int stalls);
        in_valid = 1'b1;
        in_prod  = p;
        in_first = f;
        in_last  = l;
        stalls   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stalls++;
            if (stalls > 50) begin
                vectors++;
                miscompares++;
                $error("FAIL beat_timeout observed=stalled expected=accept");
                in_valid = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare the FIFO head whenever it is popped.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_out observed=%0h expected=none",
                       {out_sat, out_data});
            end else begin
                check("out_result", {15'b0, out_sat, out_data},
                      {15'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int st;
        int v;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        frac_shift  = 6'd4;
        in_valid    = 1'b0;
        in_prod     = '0;
        in_first    = 1'b0;
        in_last     = 1'b0;
        out_ready   = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Three-beat group and output latency
        exp_q.push_back({1'b0, 16'd16});
        beat(32'd100, 1'b1, 1'b0, st);
        beat(32'd200, 1'b0, 1'b0, st);
        beat(-32'sd50, 1'b0, 1'b1, st);
        @(negedge clk);
        check("lat_after_edge1", out_valid, 0);
        @(negedge clk);
        check("lat_after_edge2", out_valid, 1);
        check("lat_head_data", out_data, 16);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Negative rounding
        exp_q.push_back({1'b0, 16'hffff});
        beat(-32'sd24, 1'b1, 1'b1, st);
        exp_q.push_back({1'b0, 16'hfffe});
        beat(-32'sd25, 1'b1, 1'b1, st);
        wait_drain();

        // Saturation at frac_shift=0
        frac_shift = 6'd0;
        exp_q.push_back({1'b1, 16'h7fff});
        beat(32'd1048576, 1'b1, 1'b1, st);
        exp_q.push_back({1'b1, 16'h8000});
        beat(-32'sd1048576, 1'b1, 1'b1, st);
        exp_q.push_back({1'b0, 16'h7fff});
        beat(32'd32767, 1'b1, 1'b1, st);
        exp_q.push_back({1'b1, 16'h8000});
        beat(-32'sd32769, 1'b1, 1'b1, st);
        wait_drain();

        // Backpressure
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(17'(i));
            beat(32'(i), 1'b1, 1'b1, st);
            check($sformatf("bp_accept_%0d", i), st, 0);
        end
        @(negedge clk);
        check("bp_ready_low", in_ready, 0);
        @(negedge clk);
        check("bp_ready_still_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        exp_q.push_back(17'd5);
        beat(32'd5, 1'b1, 1'b1, st);
        check("bp_beat5_stalled", (st > 0), 1);
        exp_q.push_back(17'd6);
        beat(32'd6, 1'b1, 1'b1, st);
        wait_drain();

        // Group without a first flag starts from a cleared accumulator
        exp_q.push_back(17'd15);
        beat(32'd10, 1'b1, 1'b0, st);
        beat(32'd5, 1'b0, 1'b1, st);
        exp_q.push_back(17'd10);
        beat(32'd7, 1'b0, 1'b0, st);
        beat(32'd3, 1'b0, 1'b1, st);
        wait_drain();

        // Back-to-back single-beat groups at full rate
        frac_shift = 6'd3;
        for (int i = 0; i < 8; i++) begin
            v = int'($urandom_range(200000)) - 100000;
            exp_q.push_back(model(longint'(v), 3));
            beat(32'(v), 1'b1, 1'b1, st);
            check($sformatf("tput_stall_%0d", i), st, 0);
        end
        wait_drain();

        // Reset mid-group with a result already buffered
        frac_shift = 6'd0;
        out_ready  = 1'b0;
        beat(32'd99, 1'b1, 1'b1, st);
        beat(32'd1000, 1'b1, 1'b0, st);
        beat(32'd2000, 1'b0, 1'b0, st);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("postrst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        exp_q.push_back(17'd5);
        beat(32'd5, 1'b1, 1'b1, st);
        wait_drain();
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
